// File: rtl/base_parity_pkg.sv
`default_nettype none
// ============================================================================
// Module      : base_parity_pkg
// Description : Shared segmentation helpers for the parity generator/checker
//               pair. Segment k of a data word covers [seg_lo : seg_hi] in
//               ascending bit order.
// Revision    : 1.0 - initial release
// ============================================================================
package base_parity_pkg;

  // Bits per parity segment; the last segment absorbs any shortfall.
  function automatic int calc_wwidth(input int dw, input int pw);
    return (dw + pw - 1) / pw;
  endfunction

  // First data bit covered by segment k.
  function automatic int seg_lo(input int k, input int dw, input int pw);
    return k * calc_wwidth(dw, pw);
  endfunction

  // Last data bit covered by segment k; the final segment ends at dw-1.
  function automatic int seg_hi(input int k, input int dw, input int pw);
    if (k == pw - 1) begin
      return dw - 1;
    end
    return (k + 1) * calc_wwidth(dw, pw) - 1;
  endfunction

endpackage : base_parity_pkg
`default_nettype wire

// File: rtl/base_parity_chk.sv
`default_nettype none
// ============================================================================
// Module      : base_parity_chk
// Description : Combinational odd-parity checker. Produces one error bit per
//               segment; a segment is bad when its bits XOR its parity bit
//               give zero.
// Revision    : 1.0 - initial release
// ============================================================================
module base_parity_chk
  import base_parity_pkg::*;
#(
  parameter int dwidth = 64,
  parameter int pwidth = 8
) (
  input  logic [0:dwidth-1] data,
  input  logic [0:pwidth-1] parity,
  output logic [0:pwidth-1] perr
);

  localparam int wwidth = calc_wwidth(dwidth, pwidth);

  // The last segment must own at least one data bit.
  if ((pwidth - 1) * wwidth >= dwidth) begin : g_bad_cfg
    $error("base_parity_chk: last parity segment would be empty");
  end

  for (genvar k = 0; k < pwidth; k++) begin : g_seg
    localparam int lo = seg_lo(k, dwidth, pwidth);
    localparam int hi = seg_hi(k, dwidth, pwidth);
    // Odd parity holds when data XOR parity is 1; anything else is an error.
    assign perr[k] = ~((^data[lo:hi]) ^ parity[k]);
  end

endmodule : base_parity_chk
`default_nettype wire

// File: rtl/base_parity_chk_stage.sv
`default_nettype none
// ============================================================================
// Module      : base_parity_chk_stage
// Description : Registered valid/ready stage (output register + one skid
//               entry) that forwards data/parity unchanged, flags per-segment
//               parity errors with each beat and keeps a sticky error log.
// Revision    : 1.0 - initial release
// ============================================================================
module base_parity_chk_stage
  import base_parity_pkg::*;
#(
  parameter int dwidth = 64,
  parameter int pwidth = 8,
  parameter int cwidth = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_v,
  output logic              o_r,
  input  logic [0:dwidth-1] i_d,
  input  logic [0:pwidth-1] i_p,
  output logic              o_v,
  input  logic              i_r,
  output logic [0:dwidth-1] o_d,
  output logic [0:pwidth-1] o_p,
  output logic [0:pwidth-1] o_perr,
  input  logic              i_err_clr,
  output logic              o_err,
  output logic [0:pwidth-1] o_err_first,
  output logic [cwidth-1:0] o_err_cnt
);

  localparam logic [cwidth-1:0] cnt_max = {cwidth{1'b1}};

  logic [0:pwidth-1] in_perr;
  logic              accept;
  logic              take_out;
  logic              skid_full;
  logic              skid_full_nxt;
  logic              rdy;
  logic              out_v;
  logic [0:dwidth-1] out_d;
  logic [0:pwidth-1] out_p;
  logic [0:pwidth-1] out_perr;
  logic [0:dwidth-1] skid_d;
  logic [0:pwidth-1] skid_p;
  logic [0:pwidth-1] skid_perr;
  logic              err;
  logic [0:pwidth-1] err_first;
  logic [cwidth-1:0] err_cnt;

  // The check runs on the input so the stored mask travels with its beat.
  base_parity_chk #(
    .dwidth (dwidth),
    .pwidth (pwidth)
  ) u_chk (
    .data   (i_d),
    .parity (i_p),
    .perr   (in_perr)
  );

  // Handshake decode; output register can load when empty or draining.
  always_comb begin
    accept        = i_v & rdy;
    take_out      = ~out_v | i_r;
    skid_full_nxt = skid_full;
    if (take_out) begin
      skid_full_nxt = 1'b0;
    end else if (accept) begin
      skid_full_nxt = 1'b1;
    end
  end

  // Occupancy control; ready is a pure register so i_r never reaches o_r.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_v     <= 1'b0;
      skid_full <= 1'b0;
      rdy       <= 1'b0;
    end else begin
      if (take_out) begin
        out_v <= skid_full | accept;
      end
      skid_full <= skid_full_nxt;
      rdy       <= ~skid_full_nxt;
    end
  end

  // Beat storage: skid entry drains first to keep FIFO order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_d     <= '0;
      out_p     <= '0;
      out_perr  <= '0;
      skid_d    <= '0;
      skid_p    <= '0;
      skid_perr <= '0;
    end else if (take_out) begin
      if (skid_full) begin
        out_d    <= skid_d;
        out_p    <= skid_p;
        out_perr <= skid_perr;
      end else if (accept) begin
        out_d    <= i_d;
        out_p    <= i_p;
        out_perr <= in_perr;
      end
    end else if (accept) begin
      skid_d    <= i_d;
      skid_p    <= i_p;
      skid_perr <= in_perr;
    end
  end

  // Sticky error log, updated on accept; a new error beats a clear pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err       <= 1'b0;
      err_first <= '0;
      err_cnt   <= '0;
    end else if (accept && (|in_perr)) begin
      if (!err || i_err_clr) begin
        err       <= 1'b1;
        err_first <= in_perr;
        err_cnt   <= cwidth'(1);
      end else if (err_cnt != cnt_max) begin
        err_cnt <= err_cnt + 1'b1;
      end
    end else if (i_err_clr) begin
      err       <= 1'b0;
      err_first <= '0;
      err_cnt   <= '0;
    end
  end

  assign o_r         = rdy;
  assign o_v         = out_v;
  assign o_d         = out_d;
  assign o_p         = out_p;
  assign o_perr      = out_perr;
  assign o_err       = err;
  assign o_err_first = err_first;
  assign o_err_cnt   = err_cnt;

endmodule : base_parity_chk_stage
`default_nettype wire

// File: tb/tb_base_parity_chk_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_base_parity_chk_stage
// Description : Self-checking bench for base_parity_chk_stage (16b data,
//               2 parity segments, 2b error counter) with a beat scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_base_parity_chk_stage;

  localparam int dw = 16;
  localparam int pw = 2;
  localparam int cw = 2;

  typedef struct packed {
    logic [0:dw-1] d;
    logic [0:pw-1] p;
    logic [0:pw-1] perr;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_v = 1'b0;
  logic          o_r;
  logic [0:dw-1] i_d = '0;
  logic [0:pw-1] i_p = '0;
  logic          o_v;
  logic          i_r = 1'b0;
  logic [0:dw-1] o_d;
  logic [0:pw-1] o_p;
  logic [0:pw-1] o_perr;
  logic          i_err_clr = 1'b0;
  logic          o_err;
  logic [0:pw-1] o_err_first;
  logic [cw-1:0] o_err_cnt;

  int    n_checks = 0;
  int    n_errors = 0;
  beat_t sb[$];

  base_parity_chk_stage #(.dwidth(dw), .pwidth(pw), .cwidth(cw)) dut (
    .clk(clk), .rst_n(rst_n), .i_v(i_v), .o_r(o_r), .i_d(i_d), .i_p(i_p),
    .o_v(o_v), .i_r(i_r), .o_d(o_d), .o_p(o_p), .o_perr(o_perr),
    .i_err_clr(i_err_clr), .o_err(o_err), .o_err_first(o_err_first),
    .o_err_cnt(o_err_cnt)
  );

  always #5 clk = ~clk;

  // Reference: count ones per 8-bit segment; odd total with parity is good.
  function automatic logic [0:pw-1] model_perr(logic [0:dw-1] d, logic [0:pw-1] p);
    logic [0:pw-1] m;
    int ones;
    for (int k = 0; k < pw; k++) begin
      ones = p[k] ? 1 : 0;
      for (int j = 0; j < 8; j++) ones += d[k*8+j] ? 1 : 0;
      m[k] = (ones % 2 == 0);
    end
    return m;
  endfunction

  // Scoreboard: compare the presented beat, pop on delivery, push on accept.
  always @(negedge clk) begin
    if (rst_n) begin
      if (o_v) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_errors++;
          $display("FAIL sb_unexpected: o_v=1 o_d=%h with empty scoreboard", o_d);
        end else if (o_d !== sb[0].d || o_p !== sb[0].p || o_perr !== sb[0].perr) begin
          n_errors++;
          $display("FAIL sb_beat: got d=%h p=%b perr=%b want d=%h p=%b perr=%b",
                   o_d, o_p, o_perr, sb[0].d, sb[0].p, sb[0].perr);
        end
        if (i_r && sb.size() != 0) void'(sb.pop_front());
      end
      if (i_v && o_r) sb.push_back('{d: i_d, p: i_p, perr: model_perr(i_d, i_p)});
    end
  end

  // In-flight beats vanish on reset.
  always @(negedge rst_n) sb.delete();

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    n_checks++;
    if (o_v !== 1'b0 || o_r !== 1'b0 || o_d !== '0 || o_p !== '0 || o_perr !== '0) begin
      n_errors++;
      $display("FAIL reset_dp: got v=%b r=%b d=%h p=%b perr=%b want 0", o_v, o_r, o_d, o_p, o_perr);
    end
    n_checks++;
    if (o_err !== 1'b0 || o_err_first !== '0 || o_err_cnt !== '0) begin
      n_errors++;
      $display("FAIL reset_log: got err=%b first=%b cnt=%0d want 0", o_err, o_err_first, o_err_cnt);
    end
    tick();
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (o_r !== 1'b1) begin
      n_errors++;
      $display("FAIL reset_ready: got o_r=%b want 1", o_r);
    end
  endtask

  task automatic test_clean();
    i_r = 1'b1;
    i_v = 1'b1; i_d = 16'h0000; i_p = 2'b11;
    tick();
    n_checks++;
    if (o_v !== 1'b1 || o_d !== 16'h0000 || o_perr !== 2'b00) begin
      n_errors++;
      $display("FAIL clean_a: got v=%b d=%h perr=%b want 1 0000 00", o_v, o_d, o_perr);
    end
    i_d = 16'h0101; i_p = 2'b00;
    tick();
    n_checks++;
    if (o_v !== 1'b1 || o_d !== 16'h0101 || o_perr !== 2'b00) begin
      n_errors++;
      $display("FAIL clean_b: got v=%b d=%h perr=%b want 1 0101 00", o_v, o_d, o_perr);
    end
    i_v = 1'b0;
    tick();
    n_checks++;
    if (o_v !== 1'b0 || o_err !== 1'b0) begin
      n_errors++;
      $display("FAIL clean_idle: got v=%b err=%b want 0 0", o_v, o_err);
    end
  endtask

  task automatic test_single_err();
    i_v = 1'b1; i_d = 16'h0001; i_p = 2'b11;
    tick();
    i_v = 1'b0;
    n_checks++;
    if (o_perr !== 2'b01 || o_err !== 1'b1 || o_err_first !== 2'b01 || o_err_cnt !== 2'd1) begin
      n_errors++;
      $display("FAIL single_err: got perr=%b err=%b first=%b cnt=%0d want 01 1 01 1",
               o_perr, o_err, o_err_first, o_err_cnt);
    end
    tick();
  endtask

  task automatic test_backpressure();
    i_r = 1'b0;
    i_v = 1'b1; i_d = 16'h1234; i_p = 2'b10;
    tick();
    n_checks++;
    if (o_r !== 1'b1 || o_v !== 1'b1) begin
      n_errors++;
      $display("FAIL bp_first: got r=%b v=%b want 1 1", o_r, o_v);
    end
    i_d = 16'hA5C3; i_p = 2'b01;
    tick();
    n_checks++;
    if (o_r !== 1'b0) begin
      n_errors++;
      $display("FAIL bp_full: got o_r=%b want 0", o_r);
    end
    i_d = 16'hFFFF; i_p = 2'b11;
    tick();
    n_checks++;
    if (o_r !== 1'b0 || o_d !== 16'h1234) begin
      n_errors++;
      $display("FAIL bp_hold: got r=%b d=%h want 0 1234", o_r, o_d);
    end
    i_v = 1'b0;
    i_r = 1'b1;
    tick();
    n_checks++;
    if (o_r !== 1'b1 || o_v !== 1'b1 || o_d !== 16'hA5C3) begin
      n_errors++;
      $display("FAIL bp_drain: got r=%b v=%b d=%h want 1 1 a5c3", o_r, o_v, o_d);
    end
    tick();
    n_checks++;
    if (o_v !== 1'b0) begin
      n_errors++;
      $display("FAIL bp_empty: got v=%b want 0", o_v);
    end
  endtask

  task automatic test_saturation();
    i_err_clr = 1'b1;
    tick();
    i_err_clr = 1'b0;
    i_r = 1'b1;
    i_v = 1'b1; i_d = 16'h0000; i_p = 2'b01;
    tick();
    n_checks++;
    if (o_err_first !== 2'b10 || o_err_cnt !== 2'd1) begin
      n_errors++;
      $display("FAIL sat_first: got first=%b cnt=%0d want 10 1", o_err_first, o_err_cnt);
    end
    i_p = 2'b00;
    for (int i = 0; i < 4; i++) tick();
    i_v = 1'b0;
    n_checks++;
    if (o_err !== 1'b1 || o_err_first !== 2'b10 || o_err_cnt !== 2'd3) begin
      n_errors++;
      $display("FAIL sat_final: got err=%b first=%b cnt=%0d want 1 10 3", o_err, o_err_first, o_err_cnt);
    end
    tick();
  endtask

  task automatic test_clear();
    i_err_clr = 1'b1;
    tick();
    i_err_clr = 1'b0;
    n_checks++;
    if (o_err !== 1'b0 || o_err_first !== 2'b00 || o_err_cnt !== 2'd0) begin
      n_errors++;
      $display("FAIL clr_alone: got err=%b first=%b cnt=%0d want 0 00 0", o_err, o_err_first, o_err_cnt);
    end
    // Prime the log so the collision must overwrite, not just set.
    i_v = 1'b1; i_d = 16'h0000; i_p = 2'b00;
    tick();
    i_d = 16'h0001; i_p = 2'b11; i_err_clr = 1'b1;
    tick();
    i_v = 1'b0; i_err_clr = 1'b0;
    n_checks++;
    if (o_err !== 1'b1 || o_err_first !== 2'b01 || o_err_cnt !== 2'd1) begin
      n_errors++;
      $display("FAIL clr_collide: got err=%b first=%b cnt=%0d want 1 01 1", o_err, o_err_first, o_err_cnt);
    end
    tick();
  endtask

  task automatic test_async_reset();
    i_r = 1'b0;
    i_v = 1'b1; i_d = 16'h00FF; i_p = 2'b10;
    tick();
    i_d = 16'h0F0F; i_p = 2'b01;
    tick();
    i_v = 1'b0;
    n_checks++;
    if (o_v !== 1'b1 || o_r !== 1'b0) begin
      n_errors++;
      $display("FAIL ar_setup: got v=%b r=%b want 1 0", o_v, o_r);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (o_v !== 1'b0 || o_r !== 1'b0 || o_err !== 1'b0 || o_err_cnt !== 2'd0 || o_err_first !== 2'b00) begin
      n_errors++;
      $display("FAIL ar_assert: got v=%b r=%b err=%b cnt=%0d first=%b want all 0",
               o_v, o_r, o_err, o_err_cnt, o_err_first);
    end
    tick();
    rst_n = 1'b1;
    i_r = 1'b1;
    tick();
    n_checks++;
    if (o_r !== 1'b1 || o_v !== 1'b0) begin
      n_errors++;
      $display("FAIL ar_release: got r=%b v=%b want 1 0", o_r, o_v);
    end
    tick();
    tick();
    n_checks++;
    if (o_v !== 1'b0) begin
      n_errors++;
      $display("FAIL ar_stale: got v=%b d=%h want v=0", o_v, o_d);
    end
  endtask

  initial begin
    test_reset();
    test_clean();
    test_single_err();
    test_backpressure();
    test_saturation();
    test_clear();
    test_async_reset();
    n_checks++;
    if (sb.size() != 0) begin
      n_errors++;
      $display("FAIL sb_drain: got %0d undelivered beats want 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_base_parity_chk_stage
`default_nettype wire
